// File: rtl/scic_mem_arbiter_pkg.sv
// Shared definitions for the SCIC memory arbiter: address map, FSM states and
// decoded address regions.
package scic_mem_pkg;

  localparam logic [15:0] ROM_BASE  = 16'h0000;
  localparam int          ROM_WORDS = 32;
  localparam logic [15:0] RAM_BASE  = 16'h0020;
  localparam int          RAM_WORDS = 64;

  typedef enum logic [2:0] {
    IDLE,
    ROM_ACC,
    RAM_ACC,
    RAM_WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_NONE
  } region_e;

endpackage

// File: rtl/scic_mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: instruction fetch port and
// data load/store port, each with a req/ack handshake.
interface scic_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_ack, if_rdata, d_ack, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_ack, if_rdata, d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/scic_mem_arbiter_addr_decode.sv
// Combinational word-address decoder: classifies an address as ROM, RAM or
// unmapped and produces the memory-local word address.
module scic_addr_decode
  import scic_mem_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          ROM_AW    = 5,
  parameter int          RAM_AW    = 6,
  parameter logic [31:0] ROM_START = 32'(ROM_BASE),
  parameter logic [31:0] RAM_START = 32'(RAM_BASE)
) (
  input  logic [ADDR_W-1:0] addr,
  output region_e           region,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [RAM_AW-1:0] ram_addr
);

  logic [31:0] rom_off;
  logic [31:0] ram_off;

  // An address below a window's start wraps to a huge offset, so one
  // unsigned compare covers both window bounds.
  always_comb begin
    rom_off = 32'(addr) - ROM_START;
    ram_off = 32'(addr) - RAM_START;
    region  = REG_NONE;
    if (rom_off < (32'd1 << ROM_AW)) begin
      region = REG_ROM;
    end else if (ram_off < (32'd1 << RAM_AW)) begin
      region = REG_RAM;
    end
  end

  assign rom_addr = rom_off[ROM_AW-1:0];
  assign ram_addr = ram_off[RAM_AW-1:0];

endmodule

// File: rtl/scic_mem_arbiter.sv
// Arbitrates the instruction ROM and data RAM between the fetch and data
// requesters; all outputs are registered and reset to zero.
module scic_mem_arbiter
  import scic_mem_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 32,
  parameter int                ROM_AW      = 5,
  parameter int                RAM_AW      = 6,
  parameter logic [ADDR_W-1:0] RAM_BASE    = 16'h0020,
  parameter int                MAX_D_BURST = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  scic_mem_arbiter_if.slave bus,
  output logic              rom_cs,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int BW = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

  state_e            state_q, state_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              gnt_d_q, gnt_d_d;
  logic              we_q, we_d;
  logic              if_ack_q, if_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;
  logic              rom_cs_q, rom_cs_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              busy_q, busy_d;

  logic              d_win, if_win;
  logic [ADDR_W-1:0] sel_addr;
  region_e           dec_region;
  logic [ROM_AW-1:0] dec_rom_addr;
  logic [RAM_AW-1:0] dec_ram_addr;

  // D has priority until it has been granted MAX_D_BURST times while IF waited.
  assign d_win    = bus.d_req && !(bus.if_req && burst_q == BURST_MAX);
  assign if_win   = bus.if_req && !d_win;
  assign sel_addr = d_win ? bus.d_addr : bus.if_addr;

  scic_addr_decode #(
    .ADDR_W    (ADDR_W),
    .ROM_AW    (ROM_AW),
    .RAM_AW    (RAM_AW),
    .ROM_START (32'(ROM_BASE)),
    .RAM_START (32'(RAM_BASE))
  ) u_decode (
    .addr     (sel_addr),
    .region   (dec_region),
    .rom_addr (dec_rom_addr),
    .ram_addr (dec_ram_addr)
  );

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    gnt_d_d     = gnt_d_q;
    we_d        = we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    rom_cs_d    = 1'b0;
    rom_addr_d  = '0;
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (d_win || if_win) begin
          gnt_d_d = d_win;
          we_d    = d_win && bus.d_we;
          if (d_win && bus.if_req) begin
            if (burst_q != BURST_MAX) burst_d = burst_q + BW'(1);
          end else begin
            burst_d = '0;
          end
          if (dec_region == REG_ROM && !we_d) begin
            state_d    = ROM_ACC;
            rom_cs_d   = 1'b1;
            rom_addr_d = dec_rom_addr;
          end else if (dec_region == REG_RAM) begin
            state_d     = RAM_ACC;
            ram_cs_d    = 1'b1;
            ram_we_d    = we_d;
            ram_addr_d  = dec_ram_addr;
            ram_wdata_d = we_d ? bus.d_wdata : '0;
          end else begin
            // Unmapped or ROM store: answer at once; a fetch gets a NOP.
            state_d = RESP;
            if (d_win) begin
              d_ack_d   = 1'b1;
              d_err_d   = 1'b1;
              d_rdata_d = '0;
            end else begin
              if_ack_d   = 1'b1;
              if_rdata_d = '0;
            end
          end
        end
      end
      ROM_ACC: begin
        state_d = RESP;
        if (gnt_d_q) begin
          d_ack_d   = 1'b1;
          d_rdata_d = rom_data;
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = rom_data;
        end
      end
      RAM_ACC: begin
        if (we_q) begin
          state_d = RESP;
          d_ack_d = 1'b1;
        end else begin
          state_d = RAM_WAIT;
        end
      end
      RAM_WAIT: begin
        state_d = RESP;
        if (gnt_d_q) begin
          d_ack_d   = 1'b1;
          d_rdata_d = ram_rdata;
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = ram_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      gnt_d_q     <= 1'b0;
      we_q        <= 1'b0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      gnt_d_q     <= gnt_d_d;
      we_q        <= we_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      rom_cs_q    <= rom_cs_d;
      rom_addr_q  <= rom_addr_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.if_ack   = if_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_err    = d_err_q;
  assign rom_cs       = rom_cs_q;
  assign rom_addr     = rom_addr_q;
  assign ram_cs       = ram_cs_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_scic_mem_arbiter.sv
// Bench for scic_mem_arbiter: directed vector table, arbitration and reset
// sequences, then random single transactions against a transaction-level model.
module tb_scic_mem_arbiter;

  localparam int MAX_D_BURST = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rom_cs;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        ram_cs;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  scic_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  scic_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  function automatic logic [31:0] rom_val(input logic [4:0] a);
    return 32'h4000_000f + {19'b0, a, 8'b0};
  endfunction

  assign rom_data = rom_cs ? rom_val(rom_addr) : 32'h0;

  logic [31:0] ram_mem [64];
  initial for (int i = 0; i < 64; i++) ram_mem[i] = 32'h0;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  int total = 0;
  int bad = 0;
  int stray = 0;
  int cs_clash = 0;

  always @(negedge clk) if (rom_cs && ram_cs) cs_clash++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Transaction-level reference: region by address range, fixed latencies.
  logic [31:0] shadow [64];
  initial for (int i = 0; i < 64; i++) shadow[i] = 32'h0;

  function automatic void model(input bit is_d, input bit we, input logic [15:0] a,
                                input logic [31:0] wd, output int lat, output logic [31:0] rd,
                                output bit chk_rd, output bit err, output int nr,
                                output int nm, output int nw);
    int ai;
    ai = int'({16'b0, a});
    lat = 1; rd = 32'h0; chk_rd = 1'b1; err = 1'b0; nr = 0; nm = 0; nw = 0;
    if (ai < 32 && !(is_d && we)) begin
      lat = 2; rd = rom_val(a[4:0]); nr = 1;
    end else if (ai >= 32 && ai < 96) begin
      nm = 1;
      if (is_d && we) begin
        lat = 2; nw = 1; chk_rd = 1'b0; shadow[ai-32] = wd;
      end else begin
        lat = 3; rd = shadow[ai-32];
      end
    end else begin
      err = is_d;
    end
  endfunction

  task automatic run_op(input bit is_d, input bit we, input logic [15:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err,
                        output int nr, output int nm, output int nw);
    bit got;
    @(posedge clk); #1;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    got = 1'b0; lat = -1; rd = 32'h0; err = 1'b0; nr = 0; nm = 0; nw = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(posedge clk); #1;
      nr += int'(rom_cs);
      nm += int'(ram_cs);
      nw += int'(ram_cs && ram_we);
      if (is_d ? bus.if_ack : bus.d_ack) stray++;
      if (is_d ? bus.d_ack : bus.if_ack) begin
        got = 1'b1; lat = c;
        rd  = is_d ? bus.d_rdata : bus.if_rdata;
        err = bus.d_err;
      end else if (c == 1) begin
        // Operands changing after the grant must not matter.
        if (is_d) begin
          bus.d_addr = 16'($urandom); bus.d_wdata = $urandom; bus.d_we = 1'($urandom);
        end else begin
          bus.if_addr = 16'($urandom);
        end
      end
    end
    bus.d_req = 1'b0;
    bus.if_req = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          chk_rd;
    logic [31:0] rd;
    bit          err;
    int          nr;
    int          nm;
    int          nw;
  } vec_t;

  function automatic vec_t mk(input string n, input bit is_d, input bit we, input logic [15:0] a,
                              input logic [31:0] wd, input int lat, input bit cr,
                              input logic [31:0] rd, input bit err, input int nr,
                              input int nm, input int nw);
    vec_t v;
    v.name = n; v.is_d = is_d; v.we = we; v.addr = a; v.wdata = wd; v.lat = lat;
    v.chk_rd = cr; v.rd = rd; v.err = err; v.nr = nr; v.nm = nm; v.nw = nw;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [11];
    int          lat, nr, nm, nw, m_lat, m_nr, m_nm, m_nw;
    logic [31:0] rd, m_rd;
    logic        err;
    bit          m_chk, m_err;
    bit          order [$];
    int          acks;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({bus.if_ack, bus.d_ack, bus.d_err, rom_cs, ram_cs, ram_we, busy}), 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_addr", 32'({rom_addr, ram_addr, ram_wdata != 32'h0}), 32'h0);
    rst_n = 1'b1;

    vecs[0]  = mk("if_rom0",   0, 0, 16'h0000, 32'h0,         2, 1, 32'h4000_000f, 0, 1, 0, 0);
    vecs[1]  = mk("d_st_5f",   1, 1, 16'h005F, 32'h0000_000F, 2, 0, 32'h0,         0, 0, 1, 1);
    vecs[2]  = mk("d_ld_5f",   1, 0, 16'h005F, 32'h0,         3, 1, 32'h0000_000F, 0, 0, 1, 0);
    vecs[3]  = mk("d_st_rom",  1, 1, 16'h0003, 32'h1234_5678, 1, 1, 32'h0,         1, 0, 0, 0);
    vecs[4]  = mk("d_ld_unm",  1, 0, 16'h1000, 32'h0,         1, 1, 32'h0,         1, 0, 0, 0);
    vecs[5]  = mk("d_st_30",   1, 1, 16'h0030, 32'hABCD_1234, 2, 0, 32'h0,         0, 0, 1, 1);
    vecs[6]  = mk("if_ram30",  0, 0, 16'h0030, 32'h0,         3, 1, 32'hABCD_1234, 0, 0, 1, 0);
    vecs[7]  = mk("d_ld_1f",   1, 0, 16'h001F, 32'h0,         2, 1, 32'h4000_1F0F, 0, 1, 0, 0);
    vecs[8]  = mk("if_unm60",  0, 0, 16'h0060, 32'h0,         1, 1, 32'h0,         0, 0, 0, 0);
    vecs[9]  = mk("d_ld_20",   1, 0, 16'h0020, 32'h0,         3, 1, 32'h0,         0, 0, 1, 0);
    vecs[10] = mk("d_st_ffff", 1, 1, 16'hFFFF, 32'h5555_AAAA, 1, 1, 32'h0,         1, 0, 0, 0);

    foreach (vecs[i]) begin
      model(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata,
            m_lat, m_rd, m_chk, m_err, m_nr, m_nm, m_nw);
      run_op(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, err, nr, nm, nw);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].err));
      if (vecs[i].chk_rd) chk({vecs[i].name, "_rdata"}, rd, vecs[i].rd);
      chk({vecs[i].name, "_cs"}, 32'({nr[7:0], nm[7:0], nw[7:0]}),
          32'({vecs[i].nr[7:0], vecs[i].nm[7:0], vecs[i].nw[7:0]}));
    end

    // Both requesters held: expected grant order from the fairness rule.
    @(posedge clk); #1;
    bus.if_addr = 16'h0001; bus.d_addr = 16'h0021; bus.d_we = 1'b0;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    for (int c = 0; c < 100 && order.size() < 9; c++) begin
      @(posedge clk); #1;
      if (bus.d_ack) begin
        order.push_back(1'b1);
        chk("arb_d_rdata", bus.d_rdata, shadow[1]);
      end
      if (bus.if_ack) begin
        order.push_back(1'b0);
        chk("arb_if_rdata", bus.if_rdata, rom_val(5'd1));
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("arb_ack_count", order.size(), 9);
    begin
      int waited;
      waited = 0;
      for (int i = 0; i < order.size(); i++) begin
        bit exp_d;
        exp_d = (waited < MAX_D_BURST);
        waited = exp_d ? waited + 1 : 0;
        chk($sformatf("arb_grant%0d_is_d", i), 32'(order[i]), 32'(exp_d));
      end
    end

    // Reset during RAM_WAIT of a load.
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0040;
    @(posedge clk); #1;
    chk("rstA_ram_cs_acc", 32'(ram_cs), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0; bus.d_req = 1'b0;
    #1;
    chk("rstA_ctrl", 32'({bus.if_ack, bus.d_ack, bus.d_err, rom_cs, ram_cs, ram_we, busy}), 32'h0);
    chk("rstA_data", bus.if_rdata | bus.d_rdata | ram_wdata | 32'(ram_addr) | 32'(rom_addr), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      acks += int'(bus.d_ack) + int'(bus.if_ack);
    end
    chk("rstA_no_ack", acks, 0);
    model(1, 0, 16'h0040, 32'h0, m_lat, m_rd, m_chk, m_err, m_nr, m_nm, m_nw);
    run_op(1, 0, 16'h0040, 32'h0, lat, rd, err, nr, nm, nw);
    chk("rstA_next_lat", lat, m_lat);
    chk("rstA_next_rdata", rd, m_rd);

    // Reset before the RAM_ACC edge of a store: nothing written.
    model(1, 1, 16'h0041, 32'h1111_2222, m_lat, m_rd, m_chk, m_err, m_nr, m_nm, m_nw);
    run_op(1, 1, 16'h0041, 32'h1111_2222, lat, rd, err, nr, nm, nw);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0041; bus.d_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("rstB_ram_we_acc", 32'(ram_we), 32'h1);
    rst_n = 1'b0; bus.d_req = 1'b0;
    #1;
    chk("rstB_cs_cleared", 32'({ram_cs, ram_we}), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model(1, 0, 16'h0041, 32'h0, m_lat, m_rd, m_chk, m_err, m_nr, m_nm, m_nw);
    run_op(1, 0, 16'h0041, 32'h0, lat, rd, err, nr, nm, nw);
    chk("rstB_not_committed", rd, m_rd);

    // Reset after the RAM_ACC edge of a store: write already done.
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0042; bus.d_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; bus.d_req = 1'b0;
    #1;
    chk("rstC_ack_cleared", 32'(bus.d_ack), 32'h0);
    model(1, 1, 16'h0042, 32'hCAFE_F00D, m_lat, m_rd, m_chk, m_err, m_nr, m_nm, m_nw);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model(1, 0, 16'h0042, 32'h0, m_lat, m_rd, m_chk, m_err, m_nr, m_nm, m_nw);
    run_op(1, 0, 16'h0042, 32'h0, lat, rd, err, nr, nm, nw);
    chk("rstC_committed", rd, m_rd);

    // Random single transactions against the model.
    for (int n = 0; n < 60; n++) begin
      bit          is_d, we;
      logic [15:0] a;
      logic [31:0] wd;
      is_d = 1'($urandom);
      we   = is_d && 1'($urandom);
      a    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
      wd   = $urandom;
      model(is_d, we, a, wd, m_lat, m_rd, m_chk, m_err, m_nr, m_nm, m_nw);
      run_op(is_d, we, a, wd, lat, rd, err, nr, nm, nw);
      chk($sformatf("rnd%0d_lat@%h", n, a), lat, m_lat);
      chk($sformatf("rnd%0d_err@%h", n, a), 32'(err), 32'(m_err));
      if (m_chk) chk($sformatf("rnd%0d_rdata@%h", n, a), rd, m_rd);
      chk($sformatf("rnd%0d_cs@%h", n, a), 32'({nr[7:0], nm[7:0], nw[7:0]}),
          32'({m_nr[7:0], m_nm[7:0], m_nw[7:0]}));
    end

    chk("stray_ack", stray, 0);
    chk("cs_exclusive", cs_clash, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
